ebr_stream_fifo: RTL and testbench

- Synchronous FIFO controller that drives one 1024x16 EBR in write mode 0 / read mode 0 (non-inverted clock equivalent). It sits directly upstream of and around the RAM primitive.
- Accepts a valid/ready input stream and generates the RAM write port signals.
- Issues RAM reads and absorbs the RAM's 1-cycle registered read latency in a 2-entry output buffer, presenting a first-word-fall-through valid/ready output stream.
- Used for camera line buffering and SPI/host rate decoupling.

---
 rtl/ebr_stream_fifo_if.sv | 42 ++++
 rtl/ebr_stream_fifo.sv | 173 +++++++++++++++++
 tb/tb_ebr_stream_fifo.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebr_stream_fifo_if.sv
// Stream and RAM-port bundle for ebr_stream_fifo.
// slave: the FIFO controller side. master: the producer/consumer/RAM side.
interface ebr_stream_fifo_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  // Input stream
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  // Output stream (first-word-fall-through)
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Occupancy: RAM + in-flight read + output buffer
  logic [ADDR_W+1:0] level;

  // EBR write port
  logic              ram_we;
  logic [12:0]       ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_mask;

  // EBR read port
  logic              ram_re;
  logic [12:0]       ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data, level,
           ram_we, ram_waddr, ram_wdata, ram_mask, ram_re, ram_raddr
  );

  modport master (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data, level,
           ram_we, ram_waddr, ram_wdata, ram_mask, ram_re, ram_raddr
  );
endinterface

// File: rtl/ebr_stream_fifo.sv
// FIFO controller wrapped around one 1024x16 EBR (write mode 0 / read mode 0).
// The RAM holds the bulk of the data; a 2-entry output buffer absorbs the RAM's
// one-cycle registered read latency and presents a first-word-fall-through stream.
// Optional feature: define EBR_STREAM_FIFO_FLUSH_EN to add a synchronous flush input.
module ebr_stream_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input logic              clk,
  input logic              resetn,
`ifdef EBR_STREAM_FIFO_FLUSH_EN
  input logic              flush,
`endif
  ebr_stream_fifo_if.slave bus
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned LvlW = ADDR_W + 2;

  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);
  localparam logic [CntW-1:0]   CntOne  = CntW'(1);
  localparam logic [CntW-1:0]   CntFull = CntW'(1) << ADDR_W;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } obuf_state_e;

  // Clear request: acts like reset on all state (RAM contents untouched).
  logic flush_w;
`ifdef EBR_STREAM_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  obuf_state_e       state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic       in_ready;
  logic       out_valid;
  logic       pop;
  logic       capture;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] obuf_cnt;
  logic [2:0] occ;

  assign in_ready  = (cnt_q != CntFull);
  assign out_valid = (state_q != StEmpty);
  assign pop       = out_valid && bus.out_ready;
  assign capture   = inflight_q;

  // Output buffer occupancy decoded from the FSM state
  always_comb begin
    obuf_cnt = 2'd0;
    unique case (state_q)
      StOne:   obuf_cnt = 2'd1;
      StTwo:   obuf_cnt = 2'd2;
      default: obuf_cnt = 2'd0;
    endcase
  end

  // Words that will sit in the buffer after this edge if no new read is issued
  assign occ = {1'b0, obuf_cnt} + {2'b00, inflight_q} - {2'b00, pop};

  // Gated by reset/flush so nothing reaches the RAM while being cleared
  assign wr_en = resetn && !flush_w && bus.in_valid && in_ready;
  // cnt_q only counts writes already committed, so a read never hits this cycle's write address
  assign rd_en = resetn && !flush_w && (cnt_q != '0) && (occ < 3'd2);

  // Pointer, RAM count and in-flight tracking
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    inflight_d = rd_en;
    if (wr_en) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (rd_en) begin
      rptr_d = rptr_q + PtrOne;
    end
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  // Output buffer FSM: head is the presented word, tail the second entry
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (capture) begin
          state_d = StOne;
          head_d  = bus.ram_rdata;
        end
      end
      StOne: begin
        if (capture && !pop) begin
          state_d = StTwo;
          tail_d  = bus.ram_rdata;
        end else if (pop && !capture) begin
          state_d = StEmpty;
        end else if (pop && capture) begin
          head_d = bus.ram_rdata;
        end
      end
      StTwo: begin
        // Capture here is unreachable; still handled without losing order
        if (pop) begin
          head_d = tail_q;
          if (capture) begin
            tail_d = bus.ram_rdata;
          end else begin
            state_d = StOne;
          end
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  // State registers with synchronous reset; flush clears identically
  always_ff @(posedge clk) begin
    if (!resetn || flush_w) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      state_q    <= StEmpty;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_q;
  assign bus.level     = LvlW'(cnt_q) + LvlW'(inflight_q) + LvlW'(obuf_cnt);

  assign bus.ram_we    = wr_en;
  assign bus.ram_waddr = 13'(wptr_q);
  assign bus.ram_wdata = bus.in_data;
  assign bus.ram_mask  = '0;
  assign bus.ram_re    = rd_en;
  assign bus.ram_raddr = 13'(rptr_q);

  // A capture into a full buffer would drop a word; read-issue rules must prevent it
  assert property (@(posedge clk) disable iff (!resetn) !(capture && (state_q == StTwo)))
    else $error("ebr_stream_fifo: read data captured while output buffer full");

endmodule

// File: tb/tb_ebr_stream_fifo.sv
// Directed bench for ebr_stream_fifo with a behavioural 1024x16 EBR model.
// Covers reset, latency, fill to capacity, wrap/throughput, random backpressure,
// mid-operation reset and (with EBR_STREAM_FIFO_FLUSH_EN) flush.
module tb_ebr_stream_fifo;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic resetn;
`ifdef EBR_STREAM_FIFO_FLUSH_EN
  logic flush;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ebr_stream_fifo_if #(.DATA_W(16), .ADDR_W(AW)) bus ();

  ebr_stream_fifo #(
    .DATA_W(16),
    .ADDR_W(AW)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
`ifdef EBR_STREAM_FIFO_FLUSH_EN
    .flush  (flush),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // EBR model: write-through storage, registered read data
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr[9:0]] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_n;
    int rd_n;
    int first;
    int seen;
    logic prev_hold;
    logic [15:0] prev_data;

    // ---- Reset with in_valid held high
    resetn        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h5555;
    bus.out_ready = 1'b0;
`ifdef EBR_STREAM_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    chk("rst_we_pre", 32'(bus.ram_we), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_we", 32'(bus.ram_we), 0);
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
    end
    chk("rst_re", 32'(bus.ram_re), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_waddr", 32'(bus.ram_waddr), 0);
    chk("rst_raddr", 32'(bus.ram_raddr), 0);
    chk("rst_mask", 32'(bus.ram_mask), 0);

    // ---- First-word latency: write in cycle 0, visible in cycle 3
    resetn      = 1'b1;
    bus.in_data = 16'hA5A5;
    #1;
    chk("lat_we", 32'(bus.ram_we), 1);
    chk("lat_waddr", 32'(bus.ram_waddr), 0);
    chk("lat_wdata", 32'(bus.ram_wdata), 32'h0000_A5A5);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("lat_level_c1", 32'(bus.level), 1);
    chk("lat_valid_c1", 32'(bus.out_valid), 0);
    chk("lat_re_c1", 32'(bus.ram_re), 1);
    chk("lat_raddr_c1", 32'(bus.ram_raddr), 0);
    tick();
    #1;
    chk("lat_valid_c2", 32'(bus.out_valid), 0);
    chk("lat_level_c2", 32'(bus.level), 1);
    tick();
    #1;
    chk("lat_valid_c3", 32'(bus.out_valid), 1);
    chk("lat_data_c3", 32'(bus.out_data), 32'h0000_A5A5);
    chk("lat_level_c3", 32'(bus.level), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("lat_level_pop", 32'(bus.level), 0);
    chk("lat_valid_pop", 32'(bus.out_valid), 0);

    // ---- Fill to capacity with the consumer stalled: 1024 in RAM + 2 in buffer
    wr_n = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      bus.in_data = 16'(wr_n);
      #1;
      if (bus.in_ready) wr_n++;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("fill_accepted", 32'(wr_n), 1026);
    chk("fill_in_ready", 32'(bus.in_ready), 0);
    chk("fill_level", 32'(bus.level), 1026);
    chk("fill_out_valid", 32'(bus.out_valid), 1);
    chk("fill_out_data", 32'(bus.out_data), 0);

    // Drain in order
    bus.out_ready = 1'b1;
    rd_n = 0;
    for (int c = 0; c < 1200 && rd_n < 1026; c++) begin
      #1;
      if (bus.out_valid) begin
        chk("fill_drain_data", 32'(bus.out_data), 32'(rd_n));
        rd_n++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    #1;
    chk("fill_drained", 32'(rd_n), 1026);
    chk("fill_level_end", 32'(bus.level), 0);
    chk("fill_valid_end", 32'(bus.out_valid), 0);

    // ---- Throughput and pointer wrap: 3000 words, both sides always ready
    wr_n  = 0;
    rd_n  = 0;
    first = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3200 && rd_n < 3000; c++) begin
      bus.in_valid = (wr_n < 3000);
      bus.in_data  = 16'(wr_n) ^ 16'hC3C3;
      #1;
      if (bus.in_valid && bus.in_ready) wr_n++;
      if (bus.out_valid) begin
        if (first < 0) first = c;
        chk("tp_data", 32'(bus.out_data), 32'(16'(rd_n) ^ 16'hC3C3));
        rd_n++;
      end else if (first >= 0 && rd_n < 3000) begin
        chk("tp_gap", 32'(bus.out_valid), 1);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("tp_count", 32'(rd_n), 3000);
    chk("tp_latency", 32'(first), 3);
    chk("tp_level_end", 32'(bus.level), 0);

    // ---- Random backpressure: 70% in_valid, 50% out_ready
    wr_n      = 0;
    rd_n      = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 40000 && rd_n < 10000; c++) begin
      bus.in_valid  = (wr_n < 10000) && ($urandom_range(0, 9) < 7);
      bus.in_data   = 16'(wr_n) + 16'h7000;
      bus.out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (prev_hold) begin
        chk("bp_hold_valid", 32'(bus.out_valid), 1);
        chk("bp_hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.in_valid && bus.in_ready) wr_n++;
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_data", 32'(bus.out_data), 32'(16'(rd_n) + 16'h7000));
        rd_n++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("bp_count", 32'(rd_n), 10000);
    chk("bp_level_end", 32'(bus.level), 0);

    // ---- Reset mid-operation with a read in flight at level 500
    wr_n = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 600 && wr_n < 501; c++) begin
      bus.in_data = 16'(wr_n) + 16'h2000;
      #1;
      if (bus.in_ready) wr_n++;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("mid_level_501", 32'(bus.level), 501);
    bus.out_ready = 1'b1;
    #1;
    chk("mid_re_on_pop", 32'(bus.ram_re), 1);
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("mid_level_500", 32'(bus.level), 500);
    resetn = 1'b0;
    tick();
    resetn       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    #1;
    chk("mid_level_0", 32'(bus.level), 0);
    chk("mid_valid_0", 32'(bus.out_valid), 0);
    chk("mid_we", 32'(bus.ram_we), 1);
    chk("mid_waddr", 32'(bus.ram_waddr), 0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    #1;
    chk("mid_valid_c2", 32'(bus.out_valid), 0);
    tick();
    #1;
    chk("mid_valid_c3", 32'(bus.out_valid), 1);
    chk("mid_data_c3", 32'(bus.out_data), 32'h0000_1234);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("mid_level_end", 32'(bus.level), 0);

`ifdef EBR_STREAM_FIFO_FLUSH_EN
    // ---- Flush at level 10 while a write is offered
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.in_data = 16'h0100 + 16'(c);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("fl_level_10", 32'(bus.level), 10);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    #1;
    chk("fl_we_blocked", 32'(bus.ram_we), 0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("fl_level_0", 32'(bus.level), 0);
    chk("fl_valid_0", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0042;
    tick();
    bus.in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.out_valid) begin
        chk("fl_data", 32'(bus.out_data), 32'h0000_0042);
        seen++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    chk("fl_seen", 32'(seen), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
